// File: rtl/id_hazard_scoreboard_pkg.sv
// rtl/id_hazard_scoreboard_pkg.sv - shared constants and types for the decode hazard scoreboard
package id_hazard_scoreboard_pkg;

    localparam int RADDR_WIDTH_DEF = 5;
    localparam int RDATA_WIDTH_DEF = 32;
    localparam int NUM_FWD_DEF     = 2;
    localparam int TAG_WIDTH_DEF   = 3;

    localparam logic [RADDR_WIDTH_DEF-1:0] ZERO_REG = '0;
    localparam logic [RDATA_WIDTH_DEF-1:0] ZERO     = '0;

    localparam logic READ_ENABLE  = 1'b1;
    localparam logic WRITE_ENABLE = 1'b1;

    typedef enum logic [2:0] {
        SRC_ZERO,
        SRC_FWD,
        SRC_WB,
        SRC_HAZARD,
        SRC_RF
    } src_e;

endpackage

// File: rtl/id_operand_resolve.sv
// rtl/id_operand_resolve.sv - priority forwarding and hazard detection for one source operand
module id_operand_resolve
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int RADDR_WIDTH = RADDR_WIDTH_DEF,
    parameter int RDATA_WIDTH = RDATA_WIDTH_DEF,
    parameter int NUM_FWD     = NUM_FWD_DEF
) (
    input  logic                           re_i,
    input  logic [RADDR_WIDTH-1:0]         rs_i,
    input  logic [RDATA_WIDTH-1:0]         reg_rdata_i,
    input  logic [NUM_FWD-1:0]             fwd_we_i,
    input  logic [NUM_FWD*RADDR_WIDTH-1:0] fwd_waddr_i,
    input  logic [NUM_FWD*RDATA_WIDTH-1:0] fwd_wdata_i,
    input  logic [NUM_FWD-1:0]             fwd_vld_i,
    input  logic                           wb_valid_i,
    input  logic [RADDR_WIDTH-1:0]         wb_rd_i,
    input  logic [RDATA_WIDTH-1:0]         wb_wdata_i,
    input  logic [2**RADDR_WIDTH-1:0]      pend_i,
    output logic [RDATA_WIDTH-1:0]         operand_o,
    output logic                           hazard_o
);

    logic                   fwd_hit;
    logic                   fwd_ok;
    logic [RDATA_WIDTH-1:0] fwd_data;
    src_e                   src;

    // Scan oldest to youngest so the youngest matching stage overrides.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_ok   = 1'b0;
        fwd_data = '0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_we_i[k] && (fwd_waddr_i[k*RADDR_WIDTH +: RADDR_WIDTH] == rs_i)) begin
                fwd_hit  = 1'b1;
                fwd_ok   = fwd_vld_i[k];
                fwd_data = fwd_wdata_i[k*RDATA_WIDTH +: RDATA_WIDTH];
            end
        end
    end

    always_comb begin
        src = SRC_RF;
        if ((re_i != READ_ENABLE) || (rs_i == RADDR_WIDTH'(ZERO_REG))) begin
            src = SRC_ZERO;
        end else if (fwd_hit) begin
            src = fwd_ok ? SRC_FWD : SRC_HAZARD;
        end else if (wb_valid_i && (wb_rd_i == rs_i)) begin
            src = SRC_WB;
        end else if (pend_i[rs_i]) begin
            src = SRC_HAZARD;
        end
    end

    always_comb begin
        operand_o = RDATA_WIDTH'(ZERO);
        hazard_o  = 1'b0;
        case (src)
            SRC_FWD:    operand_o = fwd_data;
            SRC_WB:     operand_o = wb_wdata_i;
            SRC_RF:     operand_o = reg_rdata_i;
            SRC_HAZARD: hazard_o  = 1'b1;
            default:    operand_o = RDATA_WIDTH'(ZERO);
        endcase
    end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// rtl/id_hazard_scoreboard.sv - tagged in-flight write scoreboard, operand forwarding and issue stall
module id_hazard_scoreboard
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int RADDR_WIDTH = RADDR_WIDTH_DEF,
    parameter int RDATA_WIDTH = RDATA_WIDTH_DEF,
    parameter int NUM_FWD     = NUM_FWD_DEF,
    parameter int TAG_WIDTH   = TAG_WIDTH_DEF
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           id_valid_i,
    input  logic [RADDR_WIDTH-1:0]         id_rs1_i,
    input  logic [RADDR_WIDTH-1:0]         id_rs2_i,
    input  logic                           id_rs1_re_i,
    input  logic                           id_rs2_re_i,
    input  logic [RADDR_WIDTH-1:0]         id_rd_i,
    input  logic                           id_rd_we_i,
    input  logic [RDATA_WIDTH-1:0]         id_reg1_rdata_i,
    input  logic [RDATA_WIDTH-1:0]         id_reg2_rdata_i,
    input  logic [NUM_FWD-1:0]             fwd_we_i,
    input  logic [NUM_FWD*RADDR_WIDTH-1:0] fwd_waddr_i,
    input  logic [NUM_FWD*RDATA_WIDTH-1:0] fwd_wdata_i,
    input  logic [NUM_FWD-1:0]             fwd_vld_i,
    input  logic                           wb_valid_i,
    input  logic [RADDR_WIDTH-1:0]         wb_rd_i,
    input  logic [RDATA_WIDTH-1:0]         wb_wdata_i,
    input  logic [TAG_WIDTH-1:0]           wb_tag_i,
    input  logic                           ctrl_stall_i,
    input  logic                           flush_i,
    output logic [RDATA_WIDTH-1:0]         op1_o,
    output logic [RDATA_WIDTH-1:0]         op2_o,
    output logic                           stallreq_o,
    output logic                           issue_o,
    output logic [TAG_WIDTH-1:0]           issue_tag_o
);

    localparam int                   DEPTH   = 2 ** RADDR_WIDTH;
    localparam logic [TAG_WIDTH-1:0] MAX_OUT = TAG_WIDTH'(2 ** TAG_WIDTH - 1);

    logic [DEPTH-1:0]       pend;
    logic [TAG_WIDTH-1:0]   tag_q [DEPTH];
    logic [TAG_WIDTH-1:0]   next_tag;
    logic [TAG_WIDTH-1:0]   outstanding;
    logic [RDATA_WIDTH-1:0] op1;
    logic [RDATA_WIDTH-1:0] op2;
    logic                   hazard1;
    logic                   hazard2;
    logic                   rd_tracked;
    logic                   full;
    logic                   stall_raw;
    logic                   issue_raw;
    logic                   tracked_issue;
    logic                   wb_retire;

    id_operand_resolve #(
        .RADDR_WIDTH (RADDR_WIDTH),
        .RDATA_WIDTH (RDATA_WIDTH),
        .NUM_FWD     (NUM_FWD)
    ) u_resolve_rs1 (
        .re_i        (id_rs1_re_i),
        .rs_i        (id_rs1_i),
        .reg_rdata_i (id_reg1_rdata_i),
        .fwd_we_i    (fwd_we_i),
        .fwd_waddr_i (fwd_waddr_i),
        .fwd_wdata_i (fwd_wdata_i),
        .fwd_vld_i   (fwd_vld_i),
        .wb_valid_i  (wb_valid_i),
        .wb_rd_i     (wb_rd_i),
        .wb_wdata_i  (wb_wdata_i),
        .pend_i      (pend),
        .operand_o   (op1),
        .hazard_o    (hazard1)
    );

    id_operand_resolve #(
        .RADDR_WIDTH (RADDR_WIDTH),
        .RDATA_WIDTH (RDATA_WIDTH),
        .NUM_FWD     (NUM_FWD)
    ) u_resolve_rs2 (
        .re_i        (id_rs2_re_i),
        .rs_i        (id_rs2_i),
        .reg_rdata_i (id_reg2_rdata_i),
        .fwd_we_i    (fwd_we_i),
        .fwd_waddr_i (fwd_waddr_i),
        .fwd_wdata_i (fwd_wdata_i),
        .fwd_vld_i   (fwd_vld_i),
        .wb_valid_i  (wb_valid_i),
        .wb_rd_i     (wb_rd_i),
        .wb_wdata_i  (wb_wdata_i),
        .pend_i      (pend),
        .operand_o   (op2),
        .hazard_o    (hazard2)
    );

    // Writes to x0 are architecturally discarded, so they never consume a tag slot.
    assign rd_tracked    = (id_rd_we_i == WRITE_ENABLE) && (id_rd_i != RADDR_WIDTH'(ZERO_REG));
    assign full          = (outstanding == MAX_OUT) && rd_tracked;
    assign stall_raw     = id_valid_i && (hazard1 || hazard2 || full);
    assign issue_raw     = id_valid_i && !stall_raw && !ctrl_stall_i && !flush_i;
    assign tracked_issue = issue_raw && rd_tracked;
    assign wb_retire     = wb_valid_i && (outstanding != '0);

    assign op1_o       = rst_n_i ? op1 : RDATA_WIDTH'(ZERO);
    assign op2_o       = rst_n_i ? op2 : RDATA_WIDTH'(ZERO);
    assign stallreq_o  = rst_n_i && stall_raw;
    assign issue_o     = rst_n_i && issue_raw;
    assign issue_tag_o = next_tag;

    // The issue update follows the writeback clear so a same-rd collision keeps the new producer.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend        <= '0;
            next_tag    <= '0;
            outstanding <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            if (wb_valid_i && (tag_q[wb_rd_i] == wb_tag_i)) begin
                pend[wb_rd_i] <= 1'b0;
            end
            if (tracked_issue) begin
                pend[id_rd_i]  <= 1'b1;
                tag_q[id_rd_i] <= next_tag;
                next_tag       <= next_tag + 1'b1;
            end
            case ({tracked_issue, wb_retire})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    wb_underflow_a: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(wb_valid_i && (outstanding == '0)));

endmodule

// File: doc/id_hazard_scoreboard.md
Name: id_hazard_scoreboard

Overview:
- Parametrised operand-resolution and hazard unit for the decode stage. Generalises fixed EXE/MEM forwarding and single load-use stall.
- Tracks every in-flight register write in a tagged scoreboard and forwards from NUM_FWD pipeline stages plus writeback.
- Stalls issue on any operand not yet available, including variable-latency producers (load, div).
- Sits between the regfile read ports and the id_exe register; drives the stall request to ctrl.

Parameters:
- RADDR_WIDTH, 5, register address width; table depth is 2**RADDR_WIDTH.
- RDATA_WIDTH, 32, register data width.
- NUM_FWD, 2, forwarding stages; index 0 is youngest (EXE), NUM_FWD-1 is oldest.
- TAG_WIDTH, 3, producer tag width; max outstanding writes = 2**TAG_WIDTH-1.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- id_valid_i  in  1  valid instruction in ID
- id_rs1_i / id_rs2_i  in  RADDR_WIDTH  source addresses
- id_rs1_re_i / id_rs2_re_i  in  1  source read enables
- id_rd_i  in  RADDR_WIDTH  destination
- id_rd_we_i  in  1  destination write enable
- id_reg1_rdata_i / id_reg2_rdata_i  in  RDATA_WIDTH  regfile read data
- fwd_we_i  in  NUM_FWD  stage k writes a register
- fwd_waddr_i  in  NUM_FWD*RADDR_WIDTH  stage k dest, packed with k=0 in LSBs
- fwd_wdata_i  in  NUM_FWD*RDATA_WIDTH  stage k result
- fwd_vld_i  in  NUM_FWD  stage k result ready (0 for load in EXE, div busy)
- wb_valid_i  in  1  regfile write this cycle
- wb_rd_i  in  RADDR_WIDTH  writeback dest
- wb_wdata_i  in  RDATA_WIDTH  writeback data
- wb_tag_i  in  TAG_WIDTH  tag of the retiring producer
- ctrl_stall_i  in  1  downstream stall from ctrl
- flush_i  in  1  kill the ID instruction
- op1_o / op2_o  out  RDATA_WIDTH  resolved operands
- stallreq_o  out  1  hazard stall request to ctrl
- issue_o  out  1  ID instruction advances this cycle
- issue_tag_o  out  TAG_WIDTH  tag assigned to the issuing write; travels with the instruction to WB

Behaviour:
- Reset (rst_n_i low, async):
  - Clear pend[*], tag[*], next_tag and outstanding.
  - While rst_n_i is low: op1_o=op2_o=0, stallreq_o=0, issue_o=0.
- Per-source resolution (combinational, priority order):
  - re=0 or rs=0: operand 0, no hazard.
  - Lowest k with fwd_we_i[k] and fwd_waddr[k]==rs: if fwd_vld_i[k], use fwd_wdata[k]; else hazard.
  - Else wb_valid_i and wb_rd_i==rs: wb_wdata_i.
  - Else pend[rs]: hazard (producer beyond the forwarding window or long-latency).
  - Else regfile data.
- Stall conditions:
  - full = (outstanding == 2**TAG_WIDTH-1) and id_rd_we_i and id_rd_i!=0.
  - stallreq_o = id_valid_i and (hazard1 or hazard2 or full).
- Issue:
  - issue_o = id_valid_i and not stallreq_o and not ctrl_stall_i and not flush_i.
  - issue_tag_o = next_tag.
- Sequential update on issue_o with id_rd_we_i and rd!=0:
  - pend[rd] <= 1; tag[rd] <= next_tag.
  - next_tag <= next_tag+1, wrapping modulo 2**TAG_WIDTH.
- Sequential update on wb_valid_i:
  - Clear pend[wb_rd_i] only if tag[wb_rd_i]==wb_tag_i. A mismatch means a younger WAW producer is pending; its bit stays set.
- Simultaneous issue and writeback to the same rd: issue wins; pend stays 1 with the new tag.
- outstanding counter:
  - +1 on a tracked issue, -1 on wb_valid_i, unchanged when both occur.
  - Never underflows: wb_valid_i with outstanding==0 is a protocol error; flag it in an assertion.
- Register x0 is never marked pending.
- flush_i blocks only the ID instruction. Older in-flight entries persist and retire normally.
- Downstream requirement: every tracked issue produces exactly one wb_valid_i, including load faults, which write back or send a cancel pulse on wb_valid_i with wb_rd_i=0 and the same tag.

Decomposition:
- Shared package (defines.v):
  - RADDR_WIDTH, RDATA_WIDTH, TAG_WIDTH defaults
  - ZERO_REG, ZERO
  - READ_ENABLE/WRITE_ENABLE constants
- One natural sub-module: id_operand_resolve. It is pure combinational priority forwarding for one source and is instantiated twice. The scoreboard table, tag counter and outstanding counter stay in the top.

Test Plan:
- Back-to-back dependency: add x5 issues, then a dependent add reads x5 with EXE match and fwd_vld_i[0]=1, data 0x1234 -> op1_o=0x1234, stallreq_o=0.
- Load-use: EXE holds load x6 with fwd_vld_i[0]=0 and the next instruction reads x6 -> stallreq_o=1 for 1 cycle. Next cycle MEM forwards 0xABCD with valid -> op1_o=0xABCD, issue_o=1.
- Long-latency div: x7 issued with tag 2 and leaves the forwarding window; a reader stalls until wb_valid_i with wb_rd_i=7, tag 2, data 0x55 -> op1_o=0x55 that cycle, then pend[7]=0.
- WAW: issue x8 with tag 1, then x8 with tag 2; writeback of tag 1 -> pend[8] stays 1; writeback of tag 2 -> cleared.
- Full: with TAG_WIDTH=3, issue 7 writes without writeback -> the 8th write stalls; one wb_valid_i -> it issues the same cycle the counter drops to 6. Non-writing instructions still issue while full.
- Async reset mid-stall: assert rst_n_i low between clock edges -> pend clears immediately, stallreq_o=0. After release, a reader of x5 gets regfile data.
